// File: rtl/ks_pkg.sv
// ks_pkg: shared constants and helpers for the pipelined Kogge-Stone adder.
//   DEF_WIDTH / DEF_BLOCK : default operand width and bits per block
//   MODE_ADD / MODE_SUB   : encoding of the sub input
//   ks_levels(n)          : prefix-tree depth for an n-bit block, clog2(n)
package ks_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int ks_levels(input int n);
    int l;
    l = 0;
    while ((1 << l) < n) l++;
    return l;
  endfunction

endpackage

// File: rtl/ks_block.sv
// ks_block: combinational BLOCK-bit Kogge-Stone adder.
//   a, b : operand slices
//   ci   : carry into bit 0
//   s    : sum slice
//   co   : carry out of the top bit
module ks_block
  import ks_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  localparam int LEV = ks_levels(BLOCK);

  // g[l][i] / p[l][i]: group generate/propagate over bits [i-2^l+1 .. i]
  logic [LEV:0][BLOCK-1:0] g;
  logic [LEV:0][BLOCK-1:0] p;
  logic [BLOCK:0]          c;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar l = 1; l <= LEV; l++) begin : g_lvl
    localparam int D = 1 << (l - 1);
    for (genvar i = 0; i < BLOCK; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i-D]);
        assign p[l][i] = p[l-1][i] & p[l-1][i-D];
      end else begin : g_pass
        assign g[l][i] = g[l-1][i];
        assign p[l][i] = p[l-1][i];
      end
    end
  end

  // After the last level every prefix spans down to bit 0, so the block
  // carry-in folds in with a single AND-OR per bit.
  assign c[0] = ci;
  for (genvar i = 0; i < BLOCK; i++) begin : g_carry
    assign c[i+1] = g[LEV][i] | (p[LEV][i] & ci);
  end

  assign s  = p[0] ^ c[BLOCK-1:0];
  assign co = c[BLOCK];

endmodule

// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder: WIDTH-bit add/subtract split into NSTAGE = WIDTH/BLOCK
// Kogge-Stone blocks with a register after each block. One result per cycle,
// latency NSTAGE, valid/ready handshake with a global stall.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake
//   x1, x2, cin, sub    : operands; sub=1 gives x1-x2 (cin ignored)
//   out_valid/out_ready : result handshake
//   s, cout, ovf        : result, carry out of MSB (1 = no borrow), signed ovf
module ks_pipe_adder
  import ks_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / BLOCK;
  localparam int LAST   = NSTAGE - 1;
  localparam logic [WIDTH-1:0] BMASK = WIDTH'({BLOCK{1'b1}});

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
    $error("ks_pipe_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // Pipeline registers, index k = register after block k.
  // Operands travel whole; block k only reads its own slice.
  logic [WIDTH-1:0] a_q [NSTAGE];
  logic [WIDTH-1:0] b_q [NSTAGE];
  logic [WIDTH-1:0] s_q [NSTAGE];
  logic             c_q [NSTAGE];
  logic             v_q [NSTAGE];
  logic             ovf_q;

  // Stage inputs: stage 0 sees the preconditioned ports, stage k the regs k-1.
  logic [WIDTH-1:0] a_st [NSTAGE];
  logic [WIDTH-1:0] b_st [NSTAGE];
  logic [WIDTH-1:0] s_st [NSTAGE];
  logic             c_st [NSTAGE];
  logic             v_st [NSTAGE];

  logic [BLOCK-1:0] blk_s [NSTAGE];
  logic             blk_c [NSTAGE];
  logic [WIDTH-1:0] s_nx  [NSTAGE];

  logic adv;

  assign out_valid = v_q[LAST];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtract is x1 + ~x2 + 1; the mode is consumed here and never stored.
      assign a_st[k] = x1;
      assign b_st[k] = (sub == MODE_SUB) ? ~x2 : x2;
      assign c_st[k] = (sub == MODE_SUB) ? 1'b1 : cin;
      assign s_st[k] = '0;
      assign v_st[k] = in_valid;
    end else begin : g_body
      assign a_st[k] = a_q[k-1];
      assign b_st[k] = b_q[k-1];
      assign c_st[k] = c_q[k-1];
      assign s_st[k] = s_q[k-1];
      assign v_st[k] = v_q[k-1];
    end

    ks_block #(.BLOCK(BLOCK)) u_blk (
      .a  (a_st[k][k*BLOCK +: BLOCK]),
      .b  (b_st[k][k*BLOCK +: BLOCK]),
      .ci (c_st[k]),
      .s  (blk_s[k]),
      .co (blk_c[k])
    );

    // Lower result slices ride along; this stage fills in its own slice.
    assign s_nx[k] = (s_st[k] & ~(BMASK << (k*BLOCK)))
                   | (WIDTH'(blk_s[k]) << (k*BLOCK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= a_st[k];
        b_q[k] <= b_st[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= blk_c[k];
        v_q[k] <= v_st[k];
      end
      // b here is post-inversion, so one rule covers add and subtract.
      ovf_q <= (a_st[LAST][WIDTH-1] == b_st[LAST][WIDTH-1])
             & (s_nx[LAST][WIDTH-1] != a_st[LAST][WIDTH-1]);
    end
  end

  assign s    = s_q[LAST];
  assign cout = c_q[LAST];
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Bench for ks_pipe_adder (WIDTH=32, BLOCK=8, latency 4). An arithmetic model
// fills an expected-result queue on every accepted input; a negedge compare
// process checks handshake, hold-while-stalled and in-order results.
module tb_ks_pipe_adder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout;
  logic        ovf;

  always #5 clk = ~clk;

  ks_pipe_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t expq[$];
  int   nchk  = 0;
  int   nerr  = 0;
  int   n_acc = 0;
  int   n_ret = 0;

  // Plain arithmetic: true difference / sum, borrow as unsigned compare,
  // overflow as the exact signed result falling outside 32-bit range.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    res_t   r;
    longint sv;
    if (sb) begin
      r.s = a - b;
      r.c = (a >= b);
      sv  = longint'($signed(a)) - longint'($signed(b));
    end else begin
      {r.c, r.s} = {1'b0, a} + {1'b0, b} + 33'(ci);
      sv = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    end
    r.o = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process
  initial begin
    res_t e;
    res_t prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rule", in_ready, !out_valid | out_ready);
        if (prev_stall) chk("hold_while_stalled", {s, cout, ovf}, prev);
        if (in_valid && in_ready) begin
          expq.push_back(model(x1, x2, cin, sub));
          n_acc++;
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL spurious_result: got %0h expected none", {s, cout, ovf});
          end else begin
            e = expq.pop_front();
            chk("stream_result", {s, cout, ovf}, e);
            n_ret++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev       = {s, cout, ovf};
      end
    end
  end

  // Single transaction with literal expectation and latency check.
  task automatic one(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic sb,
                     input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    x1 = a; x2 = b; cin = ci; sub = sb; in_valid = 1'b1;
    chk({name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, LAT);
    chk(name, {s, cout, ovf}, {es, ec, eo});
    @(posedge clk); #1;
    chk({name, "_one_cycle"}, out_valid, 1'b0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (expq.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_drained"}, expq.size(), 0);
    chk({name, "_count"}, n_ret, n_acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    nerr++;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x1 = '0; x2 = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_s", s, 32'h0);
    chk("reset_cout", cout, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1'b1);

    // Pin the model with hand-computed values.
    chk("model_add", model(32'h0000_00FF, 32'h1, 1'b0, 1'b0), {32'h0000_0100, 1'b0, 1'b0});
    chk("model_sub", model(32'h8000_0000, 32'h1, 1'b0, 1'b1), {32'h7FFF_FFFF, 1'b1, 1'b1});

    one("add_ff_1",     32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    one("full_ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    one("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    one("sub_5_7",      32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    one("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    one("sub_cin_ign",  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    one("add_cin",      32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

    // Back-to-back stream, mode toggling freely per transaction.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      x1 = rnd(); x2 = rnd(); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    drain("stream");

    // Fill the pipe against a stalled consumer, then retire+accept together.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x1 = rnd(); x2 = rnd(); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    x1 = 32'h0000_0011; x2 = 32'h0000_0022; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    drain("full_pipe");

    // Random backpressure.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      x1 = rnd(); x2 = rnd(); cin = 1'($urandom); sub = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    drain("backpressure");

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      x1 = 32'h0000_1000 + 32'(i); x2 = 32'h0000_0100; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", out_valid, 1'b0);
    chk("mid_reset_s", s, 32'h0);
    chk("mid_reset_cout_ovf", {cout, ovf}, 2'b00);
    expq.delete();
    n_acc = 0;
    n_ret = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", out_valid, 1'b0);
    end
    one("after_reset", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
